// File: rtl/dual_port_ram_ctrl_pkg.sv
// Shared types and helpers for the dual-port RAM controller.
// Build option: DUAL_PORT_RAM_PARITY_EN adds per-lane parity storage and checking.
package dual_port_ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   // Widest word / lane count the merge helper handles; callers size-cast in and out.
   localparam int MAX_DW  = 64;
   localparam int MAX_NBE = 8;

   function automatic int nbe_of(input int data_w, input int byte_w);
      return data_w / byte_w;
   endfunction

   // Expand a byte-enable vector into a bit mask covering the enabled lanes.
   function automatic logic [MAX_DW-1:0] lane_mask(input logic [MAX_NBE-1:0] be,
                                                   input int              byte_w);
      logic [MAX_DW-1:0]  mask;
      logic [MAX_DW-1:0]  one_lane;
      logic [MAX_NBE-1:0] be_sh;
      mask     = '0;
      one_lane = (MAX_DW'(1) << byte_w) - MAX_DW'(1);
      be_sh    = be;
      for (int l = 0; l < MAX_NBE; l++) begin
         if (be_sh[0]) mask = mask | (one_lane << (l * byte_w));
         be_sh = be_sh >> 1;
      end
      return mask;
   endfunction

   // Enabled lanes take new_w, the rest keep old_w.
   function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0]  old_w,
                                                    input logic [MAX_DW-1:0]  new_w,
                                                    input logic [MAX_NBE-1:0] be,
                                                    input int                 byte_w);
      logic [MAX_DW-1:0] mask;
      mask = lane_mask(be, byte_w);
      return (old_w & ~mask) | (new_w & mask);
   endfunction

endpackage

// File: rtl/dual_port_ram_ctrl_if.sv
// Bus bundle between the CPU/DMA masters and the dual-port RAM controller.
// Build option: DUAL_PORT_RAM_PARITY_EN adds par_inj and a_perr/b_perr.
interface dual_port_ram_ctrl_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 16,
   parameter int BYTE_WIDTH = 8
);
   localparam int NBE = DATA_WIDTH / BYTE_WIDTH;

   logic                  ready;
   logic                  a_req;
   logic                  a_we;
   logic [ADDR_WIDTH-1:0] a_addr;
   logic [NBE-1:0]        a_be;
   logic [DATA_WIDTH-1:0] a_wdata;
   logic [DATA_WIDTH-1:0] a_rdata;
   logic                  a_rvalid;
   logic                  b_req;
   logic                  b_we;
   logic [ADDR_WIDTH-1:0] b_addr;
   logic [NBE-1:0]        b_be;
   logic [DATA_WIDTH-1:0] b_wdata;
   logic [DATA_WIDTH-1:0] b_rdata;
   logic                  b_rvalid;
`ifdef DUAL_PORT_RAM_PARITY_EN
   logic                  par_inj;
   logic [NBE-1:0]        a_perr;
   logic [NBE-1:0]        b_perr;

   modport master (
      input  ready, a_rdata, a_rvalid, b_rdata, b_rvalid, a_perr, b_perr,
      output a_req, a_we, a_addr, a_be, a_wdata,
             b_req, b_we, b_addr, b_be, b_wdata, par_inj
   );
   modport slave (
      output ready, a_rdata, a_rvalid, b_rdata, b_rvalid, a_perr, b_perr,
      input  a_req, a_we, a_addr, a_be, a_wdata,
             b_req, b_we, b_addr, b_be, b_wdata, par_inj
   );
`else
   modport master (
      input  ready, a_rdata, a_rvalid, b_rdata, b_rvalid,
      output a_req, a_we, a_addr, a_be, a_wdata,
             b_req, b_we, b_addr, b_be, b_wdata
   );
   modport slave (
      output ready, a_rdata, a_rvalid, b_rdata, b_rvalid,
      input  a_req, a_we, a_addr, a_be, a_wdata,
             b_req, b_we, b_addr, b_be, b_wdata
   );
`endif
endinterface

// File: rtl/dual_port_ram_ctrl_bank.sv
// Storage array for the dual-port RAM: two write ports with per-lane enables
// (port A owns shared lanes on a same-address double write) and write-first
// read muxes so a reader sees the other port's same-cycle write.
// Build option: DUAL_PORT_RAM_PARITY_EN stores one even-parity bit per lane.
module dpram_bank
   import dual_port_ram_pkg::*;
#(
   parameter  int ADDR_WIDTH = 4,
   parameter  int DATA_WIDTH = 16,
   parameter  int DEPTH      = 16,
   parameter  int BYTE_WIDTH = 8,
   localparam int NBE        = nbe_of(DATA_WIDTH, BYTE_WIDTH)
) (
   input  logic                  clk,
`ifdef DUAL_PORT_RAM_PARITY_EN
   input  logic                  par_inj_i,
   output logic [NBE-1:0]        a_rpar_o,
   output logic [NBE-1:0]        b_rpar_o,
`endif
   input  logic                  clr_en_i,
   input  logic [ADDR_WIDTH-1:0] clr_addr_i,
   input  logic                  a_wr_i,
   input  logic [ADDR_WIDTH-1:0] a_addr_i,
   input  logic [NBE-1:0]        a_be_i,
   input  logic [DATA_WIDTH-1:0] a_wdata_i,
   input  logic                  b_wr_i,
   input  logic [ADDR_WIDTH-1:0] b_addr_i,
   input  logic [NBE-1:0]        b_be_i,
   input  logic [DATA_WIDTH-1:0] b_wdata_i,
   output logic [DATA_WIDTH-1:0] a_rword_o,
   output logic [DATA_WIDTH-1:0] b_rword_o
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [IDX_W-1:0]      a_idx, b_idx, clr_idx;
   logic                  a_in, b_in;
   logic                  same_wr, b_hits_a, a_hits_b;
   logic [DATA_WIDTH-1:0] a_wword, b_wword;

   function automatic logic [DATA_WIDTH-1:0] merge_w(input logic [DATA_WIDTH-1:0] old_w,
                                                     input logic [DATA_WIDTH-1:0] new_w,
                                                     input logic [NBE-1:0]        be);
      return DATA_WIDTH'(byte_merge(MAX_DW'(old_w), MAX_DW'(new_w), MAX_NBE'(be), BYTE_WIDTH));
   endfunction

   // Index only the bits that address real words; range checks guard the rest.
   assign a_idx   = a_addr_i[IDX_W-1:0];
   assign b_idx   = b_addr_i[IDX_W-1:0];
   assign clr_idx = clr_addr_i[IDX_W-1:0];
   assign a_in    = (int'(a_addr_i) < DEPTH);
   assign b_in    = (int'(b_addr_i) < DEPTH);

   assign same_wr  = a_wr_i & b_wr_i & a_in & b_in & (a_addr_i == b_addr_i);
   assign b_hits_a = b_wr_i & b_in & (b_addr_i == a_addr_i);
   assign a_hits_b = a_wr_i & a_in & (a_addr_i == b_addr_i);

   // B's lanes go in first, then A's lanes overlay them when both hit one word.
   assign b_wword = merge_w(mem[b_idx], b_wdata_i, b_be_i);
   assign a_wword = merge_w(same_wr ? b_wword : mem[a_idx], a_wdata_i, a_be_i);

   // Write-first read: a reader gets the word as it will be after this edge.
   assign a_rword_o = a_in ? (b_hits_a ? b_wword : mem[a_idx]) : '0;
   assign b_rword_o = b_in ? (a_hits_b ? a_wword : mem[b_idx]) : '0;

   // Data array update: clear sweep has priority, A's merged word covers collisions.
   always_ff @(posedge clk) begin
      if (clr_en_i) begin
         mem[clr_idx] <= '0;
      end else begin
         if (b_wr_i && b_in && !same_wr) mem[b_idx] <= b_wword;
         if (a_wr_i && a_in)             mem[a_idx] <= a_wword;
      end
   end

`ifdef DUAL_PORT_RAM_PARITY_EN
   logic [NBE-1:0] par_mem [DEPTH];
   logic [NBE-1:0] a_lpar, b_lpar, a_wpar, b_wpar;

   // Even parity per lane; par_inj flips it to model a corrupted store.
   for (genvar l = 0; l < NBE; l++) begin : g_lpar
      assign a_lpar[l] = (^a_wdata_i[l*BYTE_WIDTH +: BYTE_WIDTH]) ^ par_inj_i;
      assign b_lpar[l] = (^b_wdata_i[l*BYTE_WIDTH +: BYTE_WIDTH]) ^ par_inj_i;
   end

   assign b_wpar   = (par_mem[b_idx] & ~b_be_i) | (b_lpar & b_be_i);
   assign a_wpar   = ((same_wr ? b_wpar : par_mem[a_idx]) & ~a_be_i) | (a_lpar & a_be_i);
   assign a_rpar_o = a_in ? (b_hits_a ? b_wpar : par_mem[a_idx]) : '0;
   assign b_rpar_o = b_in ? (a_hits_b ? a_wpar : par_mem[b_idx]) : '0;

   // Parity array follows the data array write for write.
   always_ff @(posedge clk) begin
      if (clr_en_i) begin
         par_mem[clr_idx] <= '0;
      end else begin
         if (b_wr_i && b_in && !same_wr) par_mem[b_idx] <= b_wpar;
         if (a_wr_i && a_in)             par_mem[a_idx] <= a_wpar;
      end
   end
`endif

endmodule

// File: rtl/dual_port_ram_ctrl.sv
// True dual-port RAM controller: clears the array after reset, then accepts
// independent read/write requests on ports A and B with 1-cycle registered reads.
// Build option: DUAL_PORT_RAM_PARITY_EN enables per-lane parity and a_perr/b_perr.
module dual_port_ram_ctrl
   import dual_port_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 16,
   parameter int BYTE_WIDTH = 8
) (
   input logic                 clk,
   input logic                 rst,
   dual_port_ram_ctrl_if.slave bus
);
   localparam int                    NBE       = nbe_of(DATA_WIDTH, BYTE_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] clr_addr_q;
   logic                  ready_q;
   logic                  clr_en;
   logic                  a_rd, a_wr, b_rd, b_wr;
   logic [DATA_WIDTH-1:0] a_rword, b_rword;
   logic [DATA_WIDTH-1:0] a_rdata_d, a_rdata_q, b_rdata_d, b_rdata_q;
   logic                  a_rvalid_q, b_rvalid_q;
`ifdef DUAL_PORT_RAM_PARITY_EN
   logic [NBE-1:0]        a_rpar, b_rpar;
   logic [NBE-1:0]        a_perr_d, b_perr_d, a_perr_q, b_perr_q;
`endif

   // Requests only count once the clear sweep has finished.
   assign clr_en = (state_q == CLEAR);
   assign a_rd   = ready_q & bus.a_req & ~bus.a_we;
   assign a_wr   = ready_q & bus.a_req &  bus.a_we;
   assign b_rd   = ready_q & bus.b_req & ~bus.b_we;
   assign b_wr   = ready_q & bus.b_req &  bus.b_we;

   // Clear FSM: zero one word per cycle, then raise ready and stay until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= CLEAR;
         clr_addr_q <= '0;
         ready_q    <= 1'b0;
      end else begin
         case (state_q)
            CLEAR: begin
               if (clr_addr_q == LAST_ADDR) begin
                  state_q <= READY;
                  ready_q <= 1'b1;
               end else begin
                  clr_addr_q <= clr_addr_q + ADDR_WIDTH'(1);
               end
            end
            READY: begin
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= CLEAR;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   dpram_bank #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .BYTE_WIDTH (BYTE_WIDTH)
   ) u_bank (
      .clk        (clk),
`ifdef DUAL_PORT_RAM_PARITY_EN
      .par_inj_i  (bus.par_inj),
      .a_rpar_o   (a_rpar),
      .b_rpar_o   (b_rpar),
`endif
      .clr_en_i   (clr_en),
      .clr_addr_i (clr_addr_q),
      .a_wr_i     (a_wr),
      .a_addr_i   (bus.a_addr),
      .a_be_i     (bus.a_be),
      .a_wdata_i  (bus.a_wdata),
      .b_wr_i     (b_wr),
      .b_addr_i   (bus.b_addr),
      .b_be_i     (bus.b_be),
      .b_wdata_i  (bus.b_wdata),
      .a_rword_o  (a_rword),
      .b_rword_o  (b_rword)
   );

   // Read data holds its last value between reads.
   always_comb begin
      a_rdata_d = a_rd ? a_rword : a_rdata_q;
      b_rdata_d = b_rd ? b_rword : b_rdata_q;
   end

   // Read return registers; reset drops any read still in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
      end else begin
         a_rdata_q  <= a_rdata_d;
         b_rdata_q  <= b_rdata_d;
         a_rvalid_q <= a_rd;
         b_rvalid_q <= b_rd;
      end
   end

   assign bus.ready    = ready_q;
   assign bus.a_rdata  = a_rdata_q;
   assign bus.a_rvalid = a_rvalid_q;
   assign bus.b_rdata  = b_rdata_q;
   assign bus.b_rvalid = b_rvalid_q;

`ifdef DUAL_PORT_RAM_PARITY_EN
   // A lane is in error when its stored parity disagrees with its data.
   for (genvar l = 0; l < NBE; l++) begin : g_chk
      assign a_perr_d[l] = a_rpar[l] ^ (^a_rword[l*BYTE_WIDTH +: BYTE_WIDTH]);
      assign b_perr_d[l] = b_rpar[l] ^ (^b_rword[l*BYTE_WIDTH +: BYTE_WIDTH]);
   end

   // Parity error flags update together with read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_perr_q <= '0;
         b_perr_q <= '0;
      end else begin
         if (a_rd) a_perr_q <= a_perr_d;
         if (b_rd) b_perr_q <= b_perr_d;
      end
   end

   assign bus.a_perr = a_perr_q;
   assign bus.b_perr = b_perr_q;
`endif

endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// Directed self-checking bench for dual_port_ram_ctrl (ADDR_WIDTH=5, DEPTH=16 so
// out-of-range addresses are reachable). Parity cases build with DUAL_PORT_RAM_PARITY_EN.
module tb_dual_port_ram_ctrl;
   localparam int AW    = 5;
   localparam int DW    = 16;
   localparam int BW    = 8;
   localparam int DEPTH = 16;
   localparam int NBE   = DW / BW;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   dual_port_ram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) bus ();

   dual_port_ram_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .BYTE_WIDTH (BW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input logic req, input logic we, input logic [AW-1:0] addr,
                        input logic [NBE-1:0] be, input logic [DW-1:0] wd);
      bus.a_req   = req;
      bus.a_we    = we;
      bus.a_addr  = addr;
      bus.a_be    = be;
      bus.a_wdata = wd;
   endtask

   task automatic set_b(input logic req, input logic we, input logic [AW-1:0] addr,
                        input logic [NBE-1:0] be, input logic [DW-1:0] wd);
      bus.b_req   = req;
      bus.b_we    = we;
      bus.b_addr  = addr;
      bus.b_be    = be;
      bus.b_wdata = wd;
   endtask

   task automatic idle();
      set_a(1'b0, 1'b0, 5'd0, 2'b00, 16'h0000);
      set_b(1'b0, 1'b0, 5'd0, 2'b00, 16'h0000);
`ifdef DUAL_PORT_RAM_PARITY_EN
      bus.par_inj = 1'b0;
`endif
   endtask

   task automatic test_reset();
      int cnt;
      bit seen_rv;
      rst = 1'b1;
      idle();
      repeat (3) step();
      n_checks++;
      if (bus.ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready: got %b want 0", bus.ready);
      end
      n_checks++;
      if ({bus.a_rvalid, bus.b_rvalid} !== 2'b00) begin
         n_fail++; $display("FAIL reset_rvalid: got %b want 00", {bus.a_rvalid, bus.b_rvalid});
      end
      n_checks++;
      if ({bus.a_rdata, bus.b_rdata} !== 32'h0) begin
         n_fail++; $display("FAIL reset_rdata: got %h want 00000000", {bus.a_rdata, bus.b_rdata});
      end
`ifdef DUAL_PORT_RAM_PARITY_EN
      n_checks++;
      if ({bus.a_perr, bus.b_perr} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_perr: got %b want 0000", {bus.a_perr, bus.b_perr});
      end
`endif
      rst = 1'b0;
      // Reads issued while clearing must be ignored.
      set_a(1'b1, 1'b0, 5'd3, 2'b00, 16'h0000);
      cnt     = 0;
      seen_rv = 1'b0;
      while (bus.ready !== 1'b1 && cnt < 40) begin
         step();
         cnt++;
         if (bus.a_rvalid === 1'b1) seen_rv = 1'b1;
      end
      idle();
      n_checks++;
      if (cnt !== 16) begin
         n_fail++; $display("FAIL clear_length: ready after %0d cycles want 16", cnt);
      end
      n_checks++;
      if (seen_rv !== 1'b0) begin
         n_fail++; $display("FAIL req_during_clear: rvalid seen %b want 0", seen_rv);
      end
   endtask

   task automatic test_clear_read();
      set_a(1'b1, 1'b0, 5'd3, 2'b00, 16'h0000);
      set_b(1'b1, 1'b0, 5'd15, 2'b00, 16'h0000);
      step();
      idle();
      n_checks++;
      if ({bus.a_rvalid, bus.a_rdata, bus.b_rvalid, bus.b_rdata} !== {1'b1, 16'h0000, 1'b1, 16'h0000}) begin
         n_fail++; $display("FAIL cleared_read: got a=%b/%h b=%b/%h want 1/0000 1/0000",
                            bus.a_rvalid, bus.a_rdata, bus.b_rvalid, bus.b_rdata);
      end
      step();
      n_checks++;
      if ({bus.a_rvalid, bus.b_rvalid} !== 2'b00) begin
         n_fail++; $display("FAIL rvalid_pulse: got %b want 00", {bus.a_rvalid, bus.b_rvalid});
      end
   endtask

   task automatic test_write_read();
      set_a(1'b1, 1'b1, 5'd3, 2'b11, 16'hBEEF);
      step();
      n_checks++;
      if (bus.b_rvalid !== 1'b0) begin
         n_fail++; $display("FAIL write_no_rvalid: got %b want 0", bus.b_rvalid);
      end
      idle();
      set_b(1'b1, 1'b0, 5'd3, 2'b00, 16'h0000);
      step();
      idle();
      n_checks++;
      if ({bus.b_rvalid, bus.b_rdata} !== {1'b1, 16'hBEEF}) begin
         n_fail++; $display("FAIL b_read_after_a_write: got %b/%h want 1/beef", bus.b_rvalid, bus.b_rdata);
      end
      step();
      n_checks++;
      if ({bus.b_rvalid, bus.b_rdata} !== {1'b0, 16'hBEEF}) begin
         n_fail++; $display("FAIL rdata_hold: got %b/%h want 0/beef", bus.b_rvalid, bus.b_rdata);
      end
      // be=00 write is a no-op, then a low-lane-only write from B.
      set_a(1'b1, 1'b1, 5'd3, 2'b00, 16'h0000);
      step();
      set_a(1'b0, 1'b0, 5'd0, 2'b00, 16'h0000);
      set_b(1'b1, 1'b1, 5'd3, 2'b01, 16'h9942);
      step();
      idle();
      set_a(1'b1, 1'b0, 5'd3, 2'b00, 16'h0000);
      step();
      idle();
      n_checks++;
      if ({bus.a_rvalid, bus.a_rdata} !== {1'b1, 16'hBE42}) begin
         n_fail++; $display("FAIL byte_enable: got %b/%h want 1/be42", bus.a_rvalid, bus.a_rdata);
      end
   endtask

   task automatic test_ww_collision();
      logic [NBE-1:0] a_be_t [3];
      logic [NBE-1:0] b_be_t [3];
      logic [DW-1:0]  exp_t  [3];
      a_be_t = '{2'b11, 2'b10, 2'b01};
      b_be_t = '{2'b01, 2'b01, 2'b11};
      exp_t  = '{16'h1234, 16'h12CD, 16'hAB34};
      for (int i = 0; i < 3; i++) begin
         set_a(1'b1, 1'b1, 5'd5, a_be_t[i], 16'h1234);
         set_b(1'b1, 1'b1, 5'd5, b_be_t[i], 16'hABCD);
         step();
         idle();
         set_a(1'b1, 1'b0, 5'd5, 2'b00, 16'h0000);
         step();
         idle();
         n_checks++;
         if ({bus.a_rvalid, bus.a_rdata} !== {1'b1, exp_t[i]}) begin
            n_fail++; $display("FAIL ww_collision_%0d: got %b/%h want 1/%h", i, bus.a_rvalid, bus.a_rdata, exp_t[i]);
         end
      end
   endtask

   task automatic test_write_first();
      set_a(1'b1, 1'b1, 5'd7, 2'b11, 16'h5555);
      step();
      set_a(1'b1, 1'b1, 5'd7, 2'b10, 16'hAAAA);
      set_b(1'b1, 1'b0, 5'd7, 2'b00, 16'h0000);
      step();
      idle();
      n_checks++;
      if ({bus.b_rvalid, bus.b_rdata} !== {1'b1, 16'hAA55}) begin
         n_fail++; $display("FAIL write_first_b: got %b/%h want 1/aa55", bus.b_rvalid, bus.b_rdata);
      end
      set_b(1'b1, 1'b1, 5'd7, 2'b01, 16'h1111);
      set_a(1'b1, 1'b0, 5'd7, 2'b00, 16'h0000);
      step();
      idle();
      n_checks++;
      if ({bus.a_rvalid, bus.a_rdata} !== {1'b1, 16'hAA11}) begin
         n_fail++; $display("FAIL write_first_a: got %b/%h want 1/aa11", bus.a_rvalid, bus.a_rdata);
      end
      set_a(1'b1, 1'b0, 5'd7, 2'b00, 16'h0000);
      set_b(1'b1, 1'b0, 5'd7, 2'b00, 16'h0000);
      step();
      idle();
      n_checks++;
      if ({bus.a_rvalid, bus.a_rdata, bus.b_rvalid, bus.b_rdata} !== {1'b1, 16'hAA11, 1'b1, 16'hAA11}) begin
         n_fail++; $display("FAIL both_read: got a=%b/%h b=%b/%h want 1/aa11 1/aa11",
                            bus.a_rvalid, bus.a_rdata, bus.b_rvalid, bus.b_rdata);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] exp_t [4];
      exp_t = '{16'h1000, 16'h1101, 16'h2202, 16'h3303};
      set_a(1'b1, 1'b1, 5'd0, 2'b11, 16'h1000);
      set_b(1'b1, 1'b1, 5'd1, 2'b11, 16'h1101);
      step();
      set_a(1'b1, 1'b1, 5'd2, 2'b11, 16'h2202);
      set_b(1'b1, 1'b1, 5'd3, 2'b11, 16'h3303);
      step();
      for (int i = 0; i < 4; i++) begin
         set_a(1'b1, 1'b0, AW'(i), 2'b00, 16'h0000);
         set_b(1'b1, 1'b0, AW'(3 - i), 2'b00, 16'h0000);
         step();
         n_checks++;
         if ({bus.a_rvalid, bus.a_rdata} !== {1'b1, exp_t[i]}) begin
            n_fail++; $display("FAIL b2b_a_%0d: got %b/%h want 1/%h", i, bus.a_rvalid, bus.a_rdata, exp_t[i]);
         end
         n_checks++;
         if ({bus.b_rvalid, bus.b_rdata} !== {1'b1, exp_t[3-i]}) begin
            n_fail++; $display("FAIL b2b_b_%0d: got %b/%h want 1/%h", i, bus.b_rvalid, bus.b_rdata, exp_t[3-i]);
         end
      end
      idle();
   endtask

   task automatic test_out_of_range();
      set_a(1'b1, 1'b1, 5'd16, 2'b11, 16'hFFFF);
      set_b(1'b1, 1'b0, 5'd16, 2'b00, 16'h0000);
      step();
      idle();
      n_checks++;
      if ({bus.b_rvalid, bus.b_rdata} !== {1'b1, 16'h0000}) begin
         n_fail++; $display("FAIL oor_read_b: got %b/%h want 1/0000", bus.b_rvalid, bus.b_rdata);
      end
      set_a(1'b1, 1'b0, 5'd20, 2'b00, 16'h0000);
      set_b(1'b1, 1'b0, 5'd0, 2'b00, 16'h0000);
      step();
      idle();
      n_checks++;
      if ({bus.a_rvalid, bus.a_rdata} !== {1'b1, 16'h0000}) begin
         n_fail++; $display("FAIL oor_read_a: got %b/%h want 1/0000", bus.a_rvalid, bus.a_rdata);
      end
      n_checks++;
      if ({bus.b_rvalid, bus.b_rdata} !== {1'b1, 16'h1000}) begin
         n_fail++; $display("FAIL oor_no_alias: got %b/%h want 1/1000", bus.b_rvalid, bus.b_rdata);
      end
   endtask

   task automatic test_rst_abort();
      int cnt;
      set_a(1'b1, 1'b0, 5'd3, 2'b00, 16'h0000);
      step();
      n_checks++;
      if (bus.a_rdata !== 16'h3303) begin
         n_fail++; $display("FAIL pre_abort_read: got %h want 3303", bus.a_rdata);
      end
      // Read still requested when reset hits before the next edge.
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.ready, bus.a_rvalid, bus.a_rdata} !== {1'b0, 1'b0, 16'h0000}) begin
         n_fail++; $display("FAIL async_reset: got ready=%b rv=%b rd=%h want 0 0 0000",
                            bus.ready, bus.a_rvalid, bus.a_rdata);
      end
      step();
      n_checks++;
      if (bus.a_rvalid !== 1'b0) begin
         n_fail++; $display("FAIL aborted_read: rvalid %b want 0", bus.a_rvalid);
      end
      rst = 1'b0;
      repeat (9) step();
      n_checks++;
      if (bus.ready !== 1'b0) begin
         n_fail++; $display("FAIL mid_clear_ready: got %b want 0", bus.ready);
      end
      // Pulse reset with the sweep at word 9; it must restart from word 0.
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      cnt = 0;
      while (bus.ready !== 1'b1 && cnt < 40) begin
         step();
         cnt++;
      end
      idle();
      n_checks++;
      if (cnt !== 16) begin
         n_fail++; $display("FAIL clear_restart: ready after %0d cycles want 16", cnt);
      end
      set_a(1'b1, 1'b0, 5'd3, 2'b00, 16'h0000);
      set_b(1'b1, 1'b0, 5'd7, 2'b00, 16'h0000);
      step();
      idle();
      n_checks++;
      if ({bus.a_rvalid, bus.a_rdata, bus.b_rvalid, bus.b_rdata} !== {1'b1, 16'h0000, 1'b1, 16'h0000}) begin
         n_fail++; $display("FAIL data_cleared: got a=%b/%h b=%b/%h want 1/0000 1/0000",
                            bus.a_rvalid, bus.a_rdata, bus.b_rvalid, bus.b_rdata);
      end
   endtask

`ifdef DUAL_PORT_RAM_PARITY_EN
   task automatic test_parity();
      logic [NBE-1:0] be_t  [3];
      logic           inj_t [3];
      logic [DW-1:0]  wd_t  [3];
      logic [DW-1:0]  rd_t  [3];
      logic [NBE-1:0] err_t [3];
      be_t  = '{2'b11, 2'b11, 2'b01};
      inj_t = '{1'b1, 1'b0, 1'b1};
      wd_t  = '{16'h00FF, 16'h00FF, 16'h7712};
      rd_t  = '{16'h00FF, 16'h00FF, 16'h0012};
      err_t = '{2'b11, 2'b00, 2'b01};
      for (int i = 0; i < 3; i++) begin
         set_a(1'b1, 1'b1, 5'd2, be_t[i], wd_t[i]);
         bus.par_inj = inj_t[i];
         step();
         idle();
         set_a(1'b1, 1'b0, 5'd2, 2'b00, 16'h0000);
         step();
         idle();
         n_checks++;
         if ({bus.a_rvalid, bus.a_rdata, bus.a_perr} !== {1'b1, rd_t[i], err_t[i]}) begin
            n_fail++; $display("FAIL parity_%0d: got %b/%h/%b want 1/%h/%b",
                               i, bus.a_rvalid, bus.a_rdata, bus.a_perr, rd_t[i], err_t[i]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_clear_read();
      test_write_read();
      test_ww_collision();
      test_write_first();
      test_back_to_back();
      test_out_of_range();
      test_rst_abort();
`ifdef DUAL_PORT_RAM_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
